// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load/start controls in, count and flags out.
// master = controller driving load/start; slave = the timer itself.
// All signals are synchronous to the timer clock.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic [WIDTH-1:0] timer_time;
  logic             running;
  logic             done;
  logic             expired;

  modport master (
    output load, load_value, start,
    input  timer_time, running, done, expired
  );

  modport slave (
    input  load, load_value, start,
    output timer_time, running, done, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// Down-counter with preset load, level start/pause, optional prescaler and auto-reload.
// Latency: outputs registered; load visible one edge later, first decrement PRESCALE edges after entering COUNT.
// No backpressure: load always wins over counting, start is a plain run/pause level.
module countdown_timer #(
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COUNT   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] time_q;
  logic [WIDTH-1:0] reload_q;
  logic [PW-1:0]    pre_q;
  logic             running_q;
  logic             done_q;
  logic             expired_q;

  assign bus.timer_time = time_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.expired    = expired_q;

  // Single FSM: reset > load > run/pause/tick; all outputs registered alongside state.
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (reset) begin
      state_q   <= IDLE;
      time_q    <= '0;
      reload_q  <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else if (bus.load) begin
      // A tick landing on the same edge as load is simply dropped.
      time_q    <= bus.load_value;
      reload_q  <= bus.load_value;
      pre_q     <= '0;
      running_q <= 1'b0;
      if (bus.load_value == '0) begin
        state_q   <= EXPIRED;
        expired_q <= 1'b1;
      end else begin
        state_q   <= ARMED;
        expired_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ARMED: begin
          // Entering COUNT never decrements; prescaler keeps any partial progress.
          if (bus.start) begin
            state_q   <= COUNT;
            running_q <= 1'b1;
          end
        end
        COUNT: begin
          if (!bus.start) begin
            state_q   <= ARMED;
            running_q <= 1'b0;
          end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            if (time_q > WIDTH'(1)) begin
              time_q <= time_q - WIDTH'(1);
            end else if (time_q == WIDTH'(1)) begin
              done_q <= 1'b1;
              if (AUTO_RELOAD) begin
                // Zero is never shown in reload mode; period is reload_q ticks.
                time_q <= reload_q;
              end else begin
                time_q    <= '0;
                expired_q <= 1'b1;
                running_q <= 1'b0;
                state_q   <= EXPIRED;
              end
            end
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end
        default: begin
          // IDLE and EXPIRED ignore start; only load or reset leaves them.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: three variants (plain, prescale 4, auto-reload) driven in lockstep.
// Each edge an independent reference model predicts outputs into per-DUT queues, popped after the edge.
// Directed phases add fixed-value checks for the listed scenarios, then a random phase.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld;
  logic [7:0] lv;
  logic       st;

  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(8)) ia ();
  countdown_timer_if #(.WIDTH(8)) ib ();
  countdown_timer_if #(.WIDTH(8)) ic ();

  assign ia.load = ld;  assign ia.load_value = lv;  assign ia.start = st;
  assign ib.load = ld;  assign ib.load_value = lv;  assign ib.start = st;
  assign ic.load = ld;  assign ic.load_value = lv;  assign ic.start = st;

  countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(1'b0)) dut_a (.clk(clk), .reset(rst), .bus(ia));
  countdown_timer #(.WIDTH(8), .PRESCALE(4), .AUTO_RELOAD(1'b0)) dut_b (.clk(clk), .reset(rst), .bus(ib));
  countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(1'b1)) dut_c (.clk(clk), .reset(rst), .bus(ic));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference model: st encodes 0 idle, 1 armed, 2 counting, 3 expired.
  typedef struct {
    int t;
    int rl;
    int pre;
    int st;
    bit dn;
    bit ex;
  } mdl_t;

  typedef struct {
    logic [7:0] t;
    logic       run;
    logic       dn;
    logic       ex;
  } exp_t;

  mdl_t ma, mb, mc;
  exp_t qa[$], qb[$], qc[$];

  function automatic mdl_t mstep(input mdl_t m, input int p, input bit ar,
                                 input bit r, input bit l, input int v, input bit s);
    mdl_t n;
    n    = m;
    n.dn = 1'b0;
    if (r) begin
      n.t = 0; n.rl = 0; n.pre = 0; n.st = 0; n.ex = 1'b0;
    end else if (l) begin
      n.t   = v;
      n.rl  = v;
      n.pre = 0;
      n.ex  = (v == 0);
      n.st  = (v == 0) ? 3 : 1;
    end else if (m.st == 1) begin
      if (s) n.st = 2;
    end else if (m.st == 2) begin
      if (!s) begin
        n.st = 1;
      end else begin
        n.pre = m.pre + 1;
        if (n.pre == p) begin
          n.pre = 0;
          if (m.t > 1) n.t = m.t - 1;
          else begin
            n.dn = 1'b1;
            if (ar) n.t = m.rl;
            else begin
              n.t = 0; n.ex = 1'b1; n.st = 3;
            end
          end
        end
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(input mdl_t m);
    exp_t e;
    e.t   = 8'(m.t);
    e.run = (m.st == 2);
    e.dn  = m.dn;
    e.ex  = m.ex;
    return e;
  endfunction

  task automatic cmp_dut(input string nm, input exp_t e, input logic [7:0] t,
                         input logic r, input logic d, input logic x);
    chk({nm, ".time"},    32'(t), 32'(e.t));
    chk({nm, ".running"}, 32'(r), 32'(e.run));
    chk({nm, ".done"},    32'(d), 32'(e.dn));
    chk({nm, ".expired"}, 32'(x), 32'(e.ex));
  endtask

  // One clock edge: predict, push, let the edge happen, then pop and compare.
  task automatic cyc();
    exp_t e;
    ma = mstep(ma, 1, 1'b0, rst, ld, int'(lv), st);
    mb = mstep(mb, 4, 1'b0, rst, ld, int'(lv), st);
    mc = mstep(mc, 1, 1'b1, rst, ld, int'(lv), st);
    qa.push_back(to_exp(ma));
    qb.push_back(to_exp(mb));
    qc.push_back(to_exp(mc));
    @(posedge clk);
    #1;
    if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
      chk("sb.empty", 32'd1, 32'd0);
    end else begin
      e = qa.pop_front(); cmp_dut("a", e, ia.timer_time, ia.running, ia.done, ia.expired);
      e = qb.pop_front(); cmp_dut("b", e, ib.timer_time, ib.running, ib.done, ib.expired);
      e = qc.pop_front(); cmp_dut("c", e, ic.timer_time, ic.running, ic.done, ic.expired);
    end
  endtask

  initial begin
    int seq1 [6];
    int seq6 [9];
    seq1 = '{5, 4, 3, 2, 1, 0};
    seq6 = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
    ma = '{0, 0, 0, 0, 1'b0, 1'b0};
    mb = ma;
    mc = ma;
    rst = 1'b1; ld = 1'b0; lv = 8'd0; st = 1'b1;

    // Reset state
    cyc();
    cyc();
    chk("rst.time", 32'(ia.timer_time), 0);
    chk("rst.flags", {29'd0, ia.running, ia.done, ia.expired}, 0);
    rst = 1'b0;

    // 1: load 5, run to expiry
    ld = 1'b1; lv = 8'd5; st = 1'b0;
    cyc();
    chk("t1.load", 32'(ia.timer_time), 5);
    ld = 1'b0; st = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t1.seq", 32'(ia.timer_time), 32'(seq1[i]));
      chk("t1.done", 32'(ia.done), (i == 5) ? 1 : 0);
    end
    cyc();
    chk("t1.exp_hold", {30'd0, ia.expired, ia.running}, 32'b10);
    chk("t1.done_once", 32'(ia.done), 0);

    // 2: pause and resume
    ld = 1'b1; lv = 8'd10; st = 1'b0;
    cyc();
    ld = 1'b0; st = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("t2.run3", 32'(ia.timer_time), 8);
    st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2.hold", 32'(ia.timer_time), 8);
      chk("t2.paused", 32'(ia.running), 0);
    end
    st = 1'b1;
    cyc();
    chk("t2.resume1", 32'(ia.timer_time), 8);
    cyc();
    chk("t2.resume2", 32'(ia.timer_time), 7);

    // 3: reset mid-count, then start without load
    ld = 1'b1; lv = 8'd200; st = 1'b0;
    cyc();
    ld = 1'b0; st = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t3.rst", {ia.timer_time, 21'd0, ia.running, ia.done, ia.expired}, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3.idle", {ia.timer_time, 23'd0, ia.done}, 0);
    end

    // 4: reload during count at 3
    ld = 1'b1; lv = 8'd6; st = 1'b0;
    cyc();
    ld = 1'b0; st = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("t4.at3", 32'(ia.timer_time), 3);
    ld = 1'b1; lv = 8'd20;
    cyc();
    ld = 1'b0;
    chk("t4.loaded", {ia.timer_time, 23'd0, ia.running}, {8'd20, 24'd0});
    cyc();
    chk("t4.count", {ia.timer_time, 23'd0, ia.running}, {8'd20, 24'd1});
    chk("t4.nodone", 32'(ia.done), 0);

    // 5: prescale 4 timing, then load 0
    ld = 1'b1; lv = 8'd2; st = 1'b0;
    cyc();
    ld = 1'b0; st = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("t5.time", 32'(ib.timer_time), (i < 5) ? 2 : ((i < 9) ? 1 : 0));
      chk("t5.done", 32'(ib.done), (i == 9) ? 1 : 0);
    end
    ld = 1'b1; lv = 8'd0;
    cyc();
    ld = 1'b0;
    chk("t5.load0", {ib.timer_time, 22'd0, ib.expired, ib.done}, 32'b10);

    // 6: auto-reload period
    ld = 1'b1; lv = 8'd3; st = 1'b0;
    cyc();
    ld = 1'b0; st = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("t6.seq", 32'(ic.timer_time), 32'(seq6[i]));
      chk("t6.done", 32'(ic.done), (i == 3 || i == 6) ? 1 : 0);
      chk("t6.noexp", 32'(ic.expired), 0);
    end
    st = 1'b0;
    cyc();
    cyc();
    chk("t6.pause", {ic.timer_time, 23'd0, ic.running}, {8'd1, 24'd0});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6.rst", {ic.timer_time, 21'd0, ic.running, ic.done, ic.expired}, 0);

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 10);
      lv  = 8'($urandom_range(0, 6));
      st  = ($urandom_range(0, 99) < 75);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
